// File: rtl/z_core_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding, the owner encoding and the burst-length width.
package z_core_pkg;

    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/z_core_mem_arbiter_if.sv
// Bus bundle between prefetcher, LSU, arbiter and the AXI master.
// slave: arbiter view (takes i_/d_ requests, drives m_ commands); master: environment view.
interface z_core_mem_arbiter_if
    import z_core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int STRB_W = DATA_W / 8;

    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic [LEN_W-1:0]  i_req_len;
    logic              i_flush;
    logic              i_rsp_valid;
    logic              i_rsp_last;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic [DATA_W-1:0] d_req_wdata;
    logic [STRB_W-1:0] d_req_wstrb;
    logic              d_rsp_valid;

    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              m_req_valid;
    logic              m_req_ready;
    logic [ADDR_W-1:0] m_req_addr;
    logic              m_req_we;
    logic [DATA_W-1:0] m_req_wdata;
    logic [STRB_W-1:0] m_req_wstrb;
    logic [LEN_W-1:0]  m_req_len;
    logic              m_rsp_valid;
    logic [DATA_W-1:0] m_rsp_data;
    logic              m_rsp_last;
    logic              m_rsp_err;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_len, i_flush,
        output i_req_ready, i_rsp_valid, i_rsp_last,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid,
        output rsp_data, rsp_err,
        output m_req_valid, m_req_addr, m_req_we, m_req_wdata,
        output m_req_wstrb, m_req_len,
        input  m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_last, m_rsp_err
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_len, i_flush,
        input  i_req_ready, i_rsp_valid, i_rsp_last,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid,
        input  rsp_data, rsp_err,
        input  m_req_valid, m_req_addr, m_req_we, m_req_wdata,
        input  m_req_wstrb, m_req_len,
        output m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_last, m_rsp_err
    );

endinterface

// File: rtl/z_core_rr_arb2.sv
// Two-way round-robin picker: req[0]=I, req[1]=D, last = 1 when D was served last.
// Ports: req (requests), last (previous winner), gnt (one-hot grant or zero).
module z_core_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/z_core_mem_arbiter.sv
// Shares one AXI master between the instruction prefetcher and the LSU.
// Ports: clk, rstn (async active-low) and bus (slave modport with all request/response lines).
module z_core_mem_arbiter
    import z_core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rstn,
    z_core_mem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic [1:0]        cand;
    logic [1:0]        gnt;
    logic              i_rdy, d_rdy, m_vld;
    logic              i_vld, i_lst, d_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    assign cand = {bus.d_req_valid, bus.i_req_valid & ~bus.i_flush};

    z_core_rr_arb2 u_rr (
        .req  (cand),
        .last (last_owner_q == OWN_D),
        .gnt  (gnt)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        len_d        = len_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        i_rdy        = 1'b0;
        d_rdy        = 1'b0;
        m_vld        = 1'b0;
        i_vld        = 1'b0;
        i_lst        = 1'b0;
        d_vld        = 1'b0;
        r_data       = '0;
        r_err        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (gnt[1]) begin
                    d_rdy   = 1'b1;
                    state_d = ST_ISSUE;
                    owner_d = OWN_D;
                    addr_d  = bus.d_req_addr;
                    len_d   = '0;
                    we_d    = bus.d_req_we;
                    wdata_d = bus.d_req_wdata;
                    wstrb_d = bus.d_req_wstrb;
                end else if (gnt[0]) begin
                    i_rdy   = 1'b1;
                    state_d = ST_ISSUE;
                    owner_d = OWN_I;
                    addr_d  = bus.i_req_addr;
                    len_d   = bus.i_req_len;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            ST_ISSUE: begin
                m_vld = 1'b1;
                if (owner_q == OWN_I && bus.i_flush) drop_d = 1'b1;
                if (bus.m_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (owner_q == OWN_I && bus.i_flush) drop_d = 1'b1;
                if (bus.m_rsp_valid) begin
                    // A flush in the same cycle already suppresses this beat.
                    if (owner_q == OWN_I) begin
                        i_vld = ~drop_q & ~bus.i_flush;
                        i_lst = i_vld & bus.m_rsp_last;
                    end else begin
                        d_vld = 1'b1;
                    end
                    if (i_vld | d_vld) begin
                        r_data = bus.m_rsp_data;
                        r_err  = bus.m_rsp_err;
                    end
                    if (bus.m_rsp_last) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                        drop_d       = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            drop_q       <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    // Readies are combinational from live inputs, so gate them while in reset.
    assign bus.i_req_ready = i_rdy & rstn;
    assign bus.d_req_ready = d_rdy & rstn;
    assign bus.i_rsp_valid = i_vld;
    assign bus.i_rsp_last  = i_lst;
    assign bus.d_rsp_valid = d_vld;
    assign bus.rsp_data    = r_data;
    assign bus.rsp_err     = r_err;
    assign bus.m_req_valid = m_vld;
    assign bus.m_req_addr  = addr_q;
    assign bus.m_req_len   = len_q;
    assign bus.m_req_we    = we_q;
    assign bus.m_req_wdata = wdata_q;
    assign bus.m_req_wstrb = wstrb_q;

endmodule

// File: doc/z_core_mem_arbiter.md
Z_CORE_MEM_ARBITER -- requirements
Module: z_core_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all request ports.
REQ-002 Parameter DATA_W, default 32: data width; write strobe width is DATA_W/8.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 i_req_valid  in  1  prefetcher burst read request.
REQ-006 i_req_ready  out  1  arbiter accepts the prefetcher request this cycle.
REQ-007 i_req_addr  in  ADDR_W  burst start address.
REQ-008 i_req_len  in  4  burst beats minus one (0..15).
REQ-009 i_flush  in  1  control-unit redirect; cancels the prefetcher's pending burst.
REQ-010 i_rsp_valid  out  1  read beat delivered to the prefetcher.
REQ-011 i_rsp_last  out  1  final beat of the prefetcher burst.
REQ-012 d_req_valid  in  1  LSU single-beat request.
REQ-013 d_req_ready  out  1  arbiter accepts the LSU request this cycle.
REQ-014 d_req_addr  in  ADDR_W  LSU address.
REQ-015 d_req_we  in  1  1 = write, 0 = read.
REQ-016 d_req_wdata  in  DATA_W  LSU write data.
REQ-017 d_req_wstrb  in  DATA_W/8  LSU byte strobes.
REQ-018 d_rsp_valid  out  1  LSU read data or write acknowledge.
REQ-019 rsp_data  out  DATA_W  response data, shared by both requesters.
REQ-020 rsp_err  out  1  response error (AXI SLVERR/DECERR), shared.
REQ-021 m_req_valid  out  1  command valid to AXI master.
REQ-022 m_req_ready  in  1  AXI master accepts the command.
REQ-023 m_req_addr / m_req_we / m_req_wdata / m_req_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  registered command fields.
REQ-024 m_req_len  out  4  beats minus one; 0 for LSU.
REQ-025 m_rsp_valid  in  1  response beat from AXI master; always accepted.
REQ-026 m_rsp_data / m_rsp_last / m_rsp_err  in  DATA_W/1/1  beat data, last flag, error.

Function
REQ-027 FSM states IDLE, ISSUE, WAIT; registers owner (I/D), last_owner, drop, and the captured command fields.
REQ-028 IDLE: candidates are I = i_req_valid & ~i_flush and D = d_req_valid; one candidate is granted; if both, the one != last_owner is granted. Only the granted *_req_ready is asserted, combinationally, in that cycle; fields are captured; next state ISSUE.
REQ-029 ISSUE: m_req_valid = 1 with stable fields until m_req_ready; then WAIT. An accept in cycle N gives m_req_valid at N+1.
REQ-030 D grant: m_req_len = 0; a read or write completes on a single beat with m_rsp_last = 1.
REQ-031 WAIT: each m_rsp_valid is routed to the owner in the same cycle. Routing drives i_rsp_valid/i_rsp_last or d_rsp_valid, with rsp_data = m_rsp_data and rsp_err = m_rsp_err. A beat with m_rsp_last returns to IDLE and sets last_owner = owner.
REQ-032 i_flush while owner = I in ISSUE or WAIT sets drop. The command is not withdrawn. The remaining beats are consumed with i_rsp_valid = 0. drop clears on entry to IDLE.
REQ-033 i_flush in IDLE blocks the I grant that cycle; D may still be granted.
REQ-034 m_rsp_valid outside WAIT is ignored. *_req_ready = 0 outside IDLE. The earliest next grant is the cycle after the last beat.

Reset
REQ-035 rstn low forces, at any time including mid-burst: state = IDLE, drop = 0, last_owner = I, all outputs = 0.

Structure
REQ-036 The state encoding, owner encoding and LEN width constant reside in shared package z_core_pkg.
REQ-037 The tie-break logic is one sub-module, z_core_rr_arb2 (2-way round-robin picker: req[1:0], last → gnt[1:0]).

Verification
REQ-038 Both valid at the first cycle after reset -> D granted first (last_owner = I); after its beat, I is granted; m_req_len = 0, then i_req_len.
REQ-039 I burst with addr 0x100, len 3, m_req_ready delayed 2 cycles -> m_req_valid is held with stable fields; 4 i_rsp_valid pulses; i_rsp_last only on the 4th.
REQ-040 i_flush during beat 2 of a len-7 burst -> beats 2..8 are consumed; i_rsp_valid = 0 from beat 2 onward; IDLE after m_rsp_last.
REQ-041 D write 0xDEADBEEF to 0x2000 with wstrb 0x3, ack with m_rsp_err = 1 -> d_rsp_valid = 1 and rsp_err = 1; i_rsp_valid stays 0.
REQ-042 rstn asserted mid-WAIT -> all outputs are 0 immediately; after release, a new I request is granted from IDLE.
